// File: rtl/inst_sram_slave.sv
// Responder for the fetch-side SRAM-like bus: word-array backed, fixed-latency,
// in-order responses with bounded outstanding requests and a stall hook.
module inst_sram_slave #(
   parameter int    ADDR_W    = 14,
   parameter int    LATENCY   = 1,
   parameter int    QDEPTH    = 2,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        stall_inject,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
      $error("inst_sram_slave: LATENCY must be in 1..7");
   end
   if (QDEPTH < 1 || QDEPTH > 4) begin : g_bad_qdepth
      $error("inst_sram_slave: QDEPTH must be in 1..4");
   end
   if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
      $error("inst_sram_slave: ADDR_W must be in 1..29");
   end

   logic [31:0]       mem [DEPTH];
   logic [31:0]       data_q [QDEPTH];
   logic [2:0]        cnt_q  [QDEPTH];
   logic [2:0]        count_q;
   logic [31:0]       data_n [QDEPTH];
   logic [2:0]        cnt_n  [QDEPTH];
   logic [2:0]        count_n;
   logic [ADDR_W-1:0] widx;
   logic [31:0]       rd_word;
   logic [2:0]        tail;
   logic              retire;
   logic              accept;
   logic              unused_addr_bits;

   assign widx             = addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

   // Handshake: a request transfers on the edge where req && addr_ok; addr_ok is
   // independent of req. data_ok is a one-cycle pulse the requester always takes.
   assign retire  = (count_q != 3'd0) && (cnt_q[0] == 3'd0);
   assign addr_ok = !reset && !stall_inject && (count_q < 3'(QDEPTH));
   assign accept  = req && addr_ok;
   assign data_ok = !reset && retire;
   assign rdata   = data_ok ? data_q[0] : 32'h0;
   assign rd_word = wr ? 32'h0 : mem[widx];
   assign tail    = count_q - {2'b0, retire};

   // Queue slot 0 is the head; retiring shifts everything down one slot.
   always_comb begin
      for (int i = 0; i < QDEPTH; i++) begin
         data_n[i] = data_q[i];
         cnt_n[i]  = cnt_q[i];
      end
      if (retire) begin
         for (int i = 0; i < QDEPTH - 1; i++) begin
            data_n[i] = data_q[i + 1];
            cnt_n[i]  = cnt_q[i + 1];
         end
         data_n[QDEPTH-1] = 32'h0;
         cnt_n[QDEPTH-1]  = 3'd0;
      end
      for (int i = 0; i < QDEPTH; i++) begin
         if (cnt_n[i] != 3'd0) cnt_n[i] = cnt_n[i] - 3'd1;
      end
      for (int i = 0; i < QDEPTH; i++) begin
         if (accept && tail == 3'(i)) begin
            data_n[i] = rd_word;
            cnt_n[i]  = 3'(LATENCY - 1);
         end
      end
      count_n = count_q - {2'b0, retire} + {2'b0, accept};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 3'd0;
         for (int i = 0; i < QDEPTH; i++) begin
            data_q[i] <= 32'h0;
            cnt_q[i]  <= 3'd0;
         end
      end else begin
         count_q <= count_n;
         for (int i = 0; i < QDEPTH; i++) begin
            data_q[i] <= data_n[i];
            cnt_q[i]  <= cnt_n[i];
         end
      end
   end

   // Array contents survive reset; accept is already gated by reset.
   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_inst_sram_slave.sv
// Bench for inst_sram_slave: three configurations share one stimulus stream,
// each checked by a due-time queue model and a response monitor.
module tb_inst_sram_slave;

   localparam int ADDR_W = 14;
   localparam int NINST  = 3;
   localparam int LATS [NINST] = '{1, 3, 2};
   localparam int QDS  [NINST] = '{2, 2, 1};

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall_inject = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL inst%0d %s cyc %0d: got %h expected %h", k, name, cyc, act, exp);
      end
   endtask

   for (genvar k = 0; k < NINST; k++) begin : g
      localparam int LAT = LATS[k];
      localparam int QD  = QDS[k];
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] rdata;
      exp_t        exp_q[$];
      int          busy_q[$];
      logic [31:0] mem_m [int];
      logic [31:0] last_rd = 32'h0;

      inst_sram_slave #(.ADDR_W(ADDR_W), .LATENCY(LAT), .QDEPTH(QD), .INIT_FILE("")) dut (
         .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
         .wdata(wdata), .stall_inject(stall_inject), .addr_ok(addr_ok),
         .data_ok(data_ok), .rdata(rdata));

      // Monitor: a response is due exactly when the head's due cycle arrives.
      always @(negedge clk) begin
         logic due_now;
         if (reset) begin
            chk(k, "data_ok_rst", 32'(data_ok), 32'h0);
            chk(k, "rdata_rst", rdata, 32'h0);
         end else begin
            due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk(k, "data_ok", 32'(data_ok), 32'(due_now));
            if (due_now) begin
               chk(k, "rdata", rdata, exp_q[0].data);
               last_rd = rdata;
               void'(exp_q.pop_front());
            end else begin
               chk(k, "rdata_idle", rdata, 32'h0);
            end
         end
      end

      // Model: decides acceptance from its own outstanding count and memory image.
      always begin
         logic        exp_ok;
         logic [31:0] resp;
         logic [31:0] word;
         int          key;
         exp_t        e;
         @(negedge clk);
         #1;
         if (reset) begin
            chk(k, "addr_ok_rst", 32'(addr_ok), 32'h0);
            busy_q.delete();
            exp_q.delete();
         end else begin
            while (busy_q.size() > 0 && busy_q[0] < cyc) void'(busy_q.pop_front());
            exp_ok = !stall_inject && (busy_q.size() < QD);
            chk(k, "addr_ok", 32'(addr_ok), 32'(exp_ok));
            if (req && exp_ok) begin
               key  = int'(addr[ADDR_W+1:2]);
               word = mem_m.exists(key) ? mem_m[key] : 32'h0;
               if (wr) begin
                  for (int b = 0; b < 4; b++) if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
                  mem_m[key] = word;
                  resp = 32'h0;
               end else begin
                  resp = word;
               end
               busy_q.push_back(cyc + LAT);
               e.data = resp;
               e.due  = cyc + LAT;
               exp_q.push_back(e);
            end
         end
      end
   end

   task automatic drive(input logic r, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic st, input logic rst = 1'b0);
      @(posedge clk);
      #1;
      req = r; wr = w; wstrb = s; addr = a; wdata = d; stall_inject = st; reset = rst;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
   endtask

   function automatic logic [31:0] rand_addr(input logic [3:0] idx);
      return {16'($urandom), 10'b0, idx, 2'($urandom)};
   endfunction

   initial begin
      repeat (3) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      idle(2);

      // Give every word in the exercised window a known value.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 4'hF, rand_addr(4'(i)), $urandom, 1'b0);
         idle(6);
      end

      // Aliased address reaches word 0.
      drive(1'b1, 1'b1, 4'hF, 32'h1c000000, 32'h02800C0C, 1'b0);
      idle(6);
      drive(1'b1, 1'b0, 4'h0, 32'h1c000000, 32'h0, 1'b0);
      idle(6);
      for (int k = 0; k < 1; k++) chk(0, "alias_word0", g[0].last_rd, 32'h02800C0C);
      chk(1, "alias_word0", g[1].last_rd, 32'h02800C0C);
      chk(2, "alias_word0", g[2].last_rd, 32'h02800C0C);

      // Back-to-back reads.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'h0, 32'(4 * i), 32'h0, 1'b0);
      idle(6);

      // req held for five cycles.
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'h0, 32'(4 * i + 16), 32'h0, 1'b0);
      idle(8);

      // Partial write followed immediately by a read of the same word.
      drive(1'b1, 1'b1, 4'hF, 32'h14, 32'h11223344, 1'b0);
      idle(6);
      drive(1'b1, 1'b1, 4'b0011, 32'h14, 32'hAABBCCDD, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0, 1'b0);
      idle(6);
      chk(0, "raw_merge", g[0].last_rd, 32'h1122CCDD);
      chk(1, "raw_merge", g[1].last_rd, 32'h1122CCDD);

      // Zero strobe still answers.
      drive(1'b1, 1'b1, 4'h0, 32'h18, 32'hFFFFFFFF, 1'b0);
      idle(6);

      // Stall hook with req held.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1);
      drive(1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b0);
      idle(6);

      // Reset with two reads outstanding.
      drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      idle(6);
      drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0, 1'b0);
      idle(6);
      chk(1, "write_survives_reset", g[1].last_rd, 32'h1122CCDD);

      // Random traffic with occasional stalls and resets.
      repeat (800) begin
         drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 4'($urandom),
               rand_addr(4'($urandom)), $urandom, $urandom_range(0, 9) == 0,
               $urandom_range(0, 99) == 0);
      end
      idle(10);

      chk(0, "drained", 32'(g[0].exp_q.size()), 32'h0);
      chk(1, "drained", 32'(g[1].exp_q.size()), 32'h0);
      chk(2, "drained", 32'(g[2].exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
